config_register_file: RTL and testbench

- Slave end of the config bus. Receives writes on the config write interface (s modport) and serves reads on the config read interface (s modport).
- Holds NUM_REGS AXIL_DATA_BITS-wide registers at a base address and exposes them in parallel to the datapath.
- Pulses a per-register update strobe on each write, so downstream logic can build stream and mem config handshakes.
- Out-of-range or misaligned reads are answered with an error response.

---
 rtl/config_register_file.sv | 115 +++++++++++
 tb/tb_config_register_file.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/config_register_file.sv
// rtl/config_register_file.sv - memory-mapped config register file with single-slot read response
// Writes are always accepted; reads return one registered response held until consumed.
module config_register_file #(
    parameter int                          AXI_ADDR_BITS  = 32,
    parameter int                          AXIL_DATA_BITS = 64,
    parameter logic [AXI_ADDR_BITS-1:0]    BASE_ADDR      = '0,
    parameter int                          NUM_REGS       = 8,
    parameter logic [AXIL_DATA_BITS-1:0]   RESET_VALUE    = '0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [AXI_ADDR_BITS-1:0]            wr_addr,
    input  logic [AXIL_DATA_BITS-1:0]           wr_data,
    input  logic                                wr_valid,
    input  logic [AXI_ADDR_BITS-1:0]            read_addr,
    input  logic                                read_valid,
    output logic                                read_ready,
    output logic [AXIL_DATA_BITS-1:0]           resp_data,
    output logic                                resp_error,
    output logic                                resp_valid,
    input  logic                                resp_ready,
    output logic [NUM_REGS*AXIL_DATA_BITS-1:0]  regs_out,
    output logic [NUM_REGS-1:0]                 reg_written
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [AXI_ADDR_BITS-1:0] STRIDE_A = AXI_ADDR_BITS'(AXIL_DATA_BITS / 8);
    localparam logic [AXI_ADDR_BITS-1:0] NREGS_A  = AXI_ADDR_BITS'(NUM_REGS);

    typedef enum logic {EMPTY, FULL} state_t;

    // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
    function automatic logic addr_hit(input logic [AXI_ADDR_BITS-1:0] addr);
        logic [AXI_ADDR_BITS-1:0] off;
        off = addr - BASE_ADDR;
        return ((off % STRIDE_A) == '0) && ((off / STRIDE_A) < NREGS_A);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [AXI_ADDR_BITS-1:0] addr);
        logic [AXI_ADDR_BITS-1:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off / STRIDE_A);
    endfunction

    logic [AXIL_DATA_BITS-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]       reg_written_q;
    state_t                    state_q;
    logic [AXIL_DATA_BITS-1:0] resp_data_q, resp_data_d;
    logic                      resp_error_q, resp_error_d;

    logic             wr_hit, rd_hit, accept;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    always_comb begin
        wr_hit       = addr_hit(wr_addr);
        wr_idx       = addr_idx(wr_addr);
        rd_hit       = addr_hit(read_addr);
        rd_idx       = addr_idx(read_addr);
        read_ready   = (state_q == EMPTY) || resp_ready;
        accept       = read_valid && read_ready;
        resp_data_d  = rd_hit ? regs_q[rd_idx] : '0;
        resp_error_d = !rd_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
            reg_written_q <= '0;
        end else begin
            reg_written_q <= '0;
            if (wr_valid && wr_hit) begin
                regs_q[wr_idx]        <= wr_data;
                reg_written_q[wr_idx] <= 1'b1;
            end
        end
    end

    // Response slot: reloads on accept even while draining, so streaming has no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q      <= FULL;
                        resp_data_q  <= resp_data_d;
                        resp_error_q <= resp_error_d;
                    end
                end
                FULL: begin
                    if (accept) begin
                        resp_data_q  <= resp_data_d;
                        resp_error_q <= resp_error_d;
                    end else if (resp_ready) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign resp_valid  = (state_q == FULL);
    assign resp_data   = resp_data_q;
    assign resp_error  = resp_error_q;
    assign reg_written = reg_written_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*AXIL_DATA_BITS +: AXIL_DATA_BITS] = regs_q[g];
    end

endmodule

// File: tb/tb_config_register_file.sv
// tb/tb_config_register_file.sv - table-driven scoreboard bench for config_register_file
module tb_config_register_file;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  wr_addr, read_addr;
    logic [63:0]  wr_data;
    logic         wr_valid, read_valid, resp_ready;
    logic         read_ready, resp_error, resp_valid;
    logic [63:0]  resp_data;
    logic [255:0] regs_out;
    logic [3:0]   reg_written;

    config_register_file #(
        .AXI_ADDR_BITS(32), .AXIL_DATA_BITS(64), .BASE_ADDR(32'h100),
        .NUM_REGS(4), .RESET_VALUE(64'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid),
        .read_addr(read_addr), .read_valid(read_valid), .read_ready(read_ready),
        .resp_data(resp_data), .resp_error(resp_error), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .regs_out(regs_out), .reg_written(reg_written)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic        e;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [3:0]  exp_strobe;
        logic        exp_err;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] mreg [4];
    logic        exp_rv;
    resp_t       sbq [$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic mhit(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h100;
        return (off[2:0] == 3'b000) && (off < 32'd32);
    endfunction

    function automatic logic [1:0] midx(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h100;
        return off[4:3];
    endfunction

    function automatic logic [255:0] mregs();
        return {mreg[3], mreg[2], mreg[1], mreg[0]};
    endfunction

    // One clock: drive inputs, check pre-edge outputs against the model, advance, check post-edge.
    task automatic step(input logic wv, input logic [31:0] wa, input logic [63:0] wd,
                        input logic rv, input logic [31:0] ra, input logic rr);
        logic       acc;
        logic [3:0] ws;
        resp_t      r;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        read_valid = rv; read_addr = ra; resp_ready = rr;
        #1;
        chk("read_ready", 256'(read_ready), 256'(!exp_rv || rr));
        if (exp_rv) begin
            if (sbq.size() == 0) begin
                chk("scoreboard_empty", 256'(1), 256'(0));
            end else begin
                chk("resp_data", 256'(resp_data), 256'(sbq[0].d));
                chk("resp_error", 256'(resp_error), 256'(sbq[0].e));
                if (rr) r = sbq.pop_front();
            end
        end
        acc = rv && (!exp_rv || rr);
        if (acc) begin
            r.d = mhit(ra) ? mreg[midx(ra)] : 64'h0;
            r.e = !mhit(ra);
            sbq.push_back(r);
        end
        ws = 4'b0000;
        if (wv && mhit(wa)) begin
            mreg[midx(wa)] = wd;
            ws[midx(wa)]   = 1'b1;
        end
        exp_rv = acc || (exp_rv && !rr);
        @(posedge clk);
        #1;
        chk("resp_valid", 256'(resp_valid), 256'(exp_rv));
        chk("reg_written", 256'(reg_written), 256'(ws));
        chk("regs_out", regs_out, mregs());
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 32'h0, 64'h0, 1'b0, 32'h0, rr);
    endtask

    vec_t tbl [10];
    int   vcnt;

    initial begin
        tbl[0] = '{32'h108,      64'hDEADBEEF,  4'b0010, 1'b0};
        tbl[1] = '{32'h100,      64'h11110000,  4'b0001, 1'b0};
        tbl[2] = '{32'h110,      64'h2222,      4'b0100, 1'b0};
        tbl[3] = '{32'h118,      64'h11,        4'b1000, 1'b0};
        tbl[4] = '{32'h120,      64'hBAD0,      4'b0000, 1'b1};
        tbl[5] = '{32'h104,      64'hBAD1,      4'b0000, 1'b1};
        tbl[6] = '{32'h0F8,      64'hBAD2,      4'b0000, 1'b1};
        tbl[7] = '{32'h0,        64'hBAD3,      4'b0000, 1'b1};
        tbl[8] = '{32'hFFFFFFF8, 64'hBAD4,      4'b0000, 1'b1};
        tbl[9] = '{32'h11F,      64'hBAD5,      4'b0000, 1'b1};

        for (int i = 0; i < 4; i++) mreg[i] = 64'h0;
        exp_rv = 1'b0;
        rst_n = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        read_valid = 1'b0; read_addr = '0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regs_out", regs_out, 256'(0));
        chk("rst_resp_valid", 256'(resp_valid), 256'(0));
        chk("rst_read_ready", 256'(read_ready), 256'(1));
        chk("rst_reg_written", 256'(reg_written), 256'(0));
        chk("rst_resp_data", 256'(resp_data), 256'(0));
        chk("rst_resp_error", 256'(resp_error), 256'(0));
        rst_n = 1'b1;
        idle(1'b1);

        // Decode table: write, then read back, then drain the response.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, tbl[i].addr, tbl[i].wdata, 1'b0, 32'h0, 1'b1);
            chk($sformatf("tbl%0d_strobe", i), 256'(reg_written), 256'(tbl[i].exp_strobe));
            idle(1'b1);
            chk($sformatf("tbl%0d_strobe_clear", i), 256'(reg_written), 256'(0));
            step(1'b0, 32'h0, 64'h0, 1'b1, tbl[i].addr, 1'b1);
            chk($sformatf("tbl%0d_resp_valid", i), 256'(resp_valid), 256'(1));
            chk($sformatf("tbl%0d_resp_error", i), 256'(resp_error), 256'(tbl[i].exp_err));
            idle(1'b1);
        end
        chk("reg1_value", regs_out[127:64], 256'(64'hDEADBEEF));

        // Held response under backpressure, then reload with no bubble.
        step(1'b0, 32'h0, 64'h0, 1'b1, 32'h100, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b0);
        chk("hold_data", 256'(resp_data), 256'(64'h11110000));
        step(1'b0, 32'h0, 64'h0, 1'b1, 32'h110, 1'b1);
        chk("reload_data", 256'(resp_data), 256'(64'h2222));
        idle(1'b1);

        // Same-cycle write and read of reg3 returns the old value.
        step(1'b1, 32'h118, 64'h55, 1'b1, 32'h118, 1'b1);
        chk("rw_old_value", 256'(resp_data), 256'(64'h11));
        step(1'b0, 32'h0, 64'h0, 1'b1, 32'h118, 1'b1);
        chk("rw_new_value", 256'(resp_data), 256'(64'h55));
        idle(1'b1);

        // Four back-to-back reads stream out on consecutive cycles.
        vcnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 64'h0, 1'b1, 32'h100 + 32'(i * 8), 1'b1);
            if (resp_valid) vcnt++;
        end
        idle(1'b1);
        if (resp_valid) vcnt++;
        chk("stream_valid_cycles", 256'(vcnt), 256'(4));

        // Asynchronous reset while a response and a strobe are pending.
        step(1'b1, 32'h108, 64'hA5A5, 1'b1, 32'h110, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_resp_valid", 256'(resp_valid), 256'(0));
        chk("arst_regs_out", regs_out, 256'(0));
        chk("arst_reg_written", 256'(reg_written), 256'(0));
        chk("arst_read_ready", 256'(read_ready), 256'(1));
        for (int i = 0; i < 4; i++) mreg[i] = 64'h0;
        sbq.delete();
        exp_rv = 1'b0;
        wr_valid = 1'b0; read_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 32'h108, 1'b1);
        chk("post_rst_read", 256'(resp_data), 256'(0));
        idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
